// File: rtl/fdivsqrt_otfc2_seq_if.sv
// rtl/fdivsqrt_otfc2_seq_if.sv - digit/handshake bundle between the div/sqrt FSM and the OTFC stage
interface fdivsqrt_otfc2_seq_if #(
   parameter int DIVb = 56
);
   localparam int W = DIVb + 4;

   logic         Start;
   logic         SqrtE;
   logic         Kill;
   logic         Step;
   logic         up;
   logic         uz;
   logic [W-1:0] U;
   logic [W-1:0] UM;
   logic [W-1:0] C;
   logic         Busy;
   logic         Done;

   modport master (
      output Start, SqrtE, Kill, Step, up, uz,
      input  U, UM, C, Busy, Done
   );

   modport slave (
      input  Start, SqrtE, Kill, Step, up, uz,
      output U, UM, C, Busy, Done
   );
endinterface

// File: rtl/fdivsqrt_otfc2_seq.sv
// rtl/fdivsqrt_otfc2_seq.sv - radix-2 on-the-fly conversion registers (U, UM, C) with iteration FSM
module fdivsqrt_otfc2_seq #(
   parameter int DIVb  = 56,
   parameter int ITERS = 57
) (
   input  logic                  clk,
   input  logic                  reset,
   fdivsqrt_otfc2_seq_if.slave   bus
);
   localparam int W  = DIVb + 4;
   localparam int CW = $clog2(ITERS + 1);

   if (ITERS < 1 || ITERS > DIVb + 1) begin : g_bad_iters
      $error("fdivsqrt_otfc2_seq: ITERS must be in 1..DIVb+1");
   end

   typedef enum logic [1:0] {
      s_idle,
      s_busy,
      s_done
   } state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  u_q, um_q, c_q;
   logic [W-1:0]  u_d, um_d, c_d;
   logic [W-1:0]  k;
   logic [CW-1:0] cnt_q, cnt_d;

   // weight of the digit about to be accepted: lowest set bit of the mask
   assign k = c_q & ~(c_q << 1);

   always_comb begin
      state_nxt = state;
      u_d       = u_q;
      um_d      = um_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      case (state)
         s_idle: begin
            if (bus.Start && !bus.Kill) begin
               state_nxt = s_busy;
               cnt_d     = '0;
               um_d      = '0;
               if (bus.SqrtE) begin
                  u_d = W'(1) << DIVb;
                  c_d = ~((W'(1) << (DIVb - 1)) - W'(1));
               end else begin
                  u_d = '0;
                  c_d = ~((W'(1) << DIVb) - W'(1));
               end
            end
         end
         s_busy: begin
            if (bus.Kill) begin
               state_nxt = s_idle;
            end else if (bus.Step) begin
               if (bus.up) begin
                  u_d  = u_q | k;
                  um_d = u_q;
               end else if (bus.uz) begin
                  um_d = um_q | k;
               end else begin
                  u_d  = um_q | k;
               end
               c_d   = {1'b1, c_q[W-1:1]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(ITERS - 1)) begin
                  state_nxt = s_done;
               end
            end
         end
         s_done:  state_nxt = s_idle;
         default: state_nxt = s_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= s_idle;
         u_q   <= '0;
         um_q  <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         u_q   <= u_d;
         um_q  <= um_d;
         c_q   <= c_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.U    = u_q;
   assign bus.UM   = um_q;
   assign bus.C    = c_q;
   assign bus.Busy = (state == s_busy);
   assign bus.Done = (state == s_done);

   // a zero prefix has no representable UM, and once C saturates K stops advancing
   a_um_inv: assert property (@(posedge clk) disable iff (reset)
      (state == s_busy && bus.Step && !bus.Kill && c_q != '1)
      |=> (u_q == '0 || um_q == u_q - $past(k)));
endmodule
